// File: rtl/ssd_scan_ctrl_if.sv
// Load handshake bundle for ssd_scan_ctrl: the producer offers a 32-bit display word.
// The producer drives the master side and the controller is the slave.
interface ssd_scan_ctrl_if;
   logic        load_valid;
   logic [31:0] load_data;
   logic        load_ready;

   modport master (output load_valid, output load_data, input load_ready);
   modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scan controller with a double-buffered display word.
// Optional leading-zero blanking is compiled in when SSD_SCAN_LZB_EN is defined.
module ssd_scan_ctrl #(
   parameter int unsigned CLK_DIV      = 50000,
   parameter int unsigned GUARD_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   ssd_scan_ctrl_if.slave    bus,
   output logic [3:0]        nibble,
   output logic [7:0]        digit_en,
   output logic              frame_done
);

   localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] GUARD = CW'(GUARD_CYCLES);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    idx, idx_nxt;
   logic [31:0]   pending_reg, preg_nxt;
   logic [31:0]   display_reg, disp_nxt;
   logic          pending, pend_nxt;
   logic          wrap, accept, commit;
   logic [7:0]    en_nxt;
   logic [3:0]    nib_nxt;
`ifdef SSD_SCAN_LZB_EN
   logic [2:0]    msd;
`endif

   assign bus.load_ready = ~pending;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         idx         <= '0;
         pending_reg <= '0;
         display_reg <= '0;
         pending     <= 1'b0;
         digit_en    <= '0;
         nibble      <= '0;
         frame_done  <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         idx         <= idx_nxt;
         pending_reg <= preg_nxt;
         display_reg <= disp_nxt;
         pending     <= pend_nxt;
         digit_en    <= en_nxt;
         nibble      <= nib_nxt;
         frame_done  <= wrap;
      end
   end

   // Outputs are registered from next-state values so they line up with the counters.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      wrap      = 1'b0;
      preg_nxt  = pending_reg;
      disp_nxt  = display_reg;
      pend_nxt  = pending;
      en_nxt    = '0;

      case (state)
         IDLE: begin
            if (enable) state_nxt = SCAN;
         end
         SCAN: begin
            if (!enable) begin
               state_nxt = IDLE;
            end else if (cnt == LAST) begin
               idx_nxt = idx + 3'd1;
               wrap    = (idx == 3'd7);
            end else begin
               cnt_nxt = cnt + CW'(1);
               idx_nxt = idx;
            end
         end
         default: state_nxt = IDLE;
      endcase

      accept = bus.load_valid && !pending;
      commit = pending && (wrap || state == IDLE);
      if (commit) begin
         disp_nxt = pending_reg;
         pend_nxt = 1'b0;
      end
      if (accept) begin
         preg_nxt = bus.load_data;
         pend_nxt = 1'b1;
      end

      nib_nxt = disp_nxt[{idx_nxt, 2'b00} +: 4];

`ifdef SSD_SCAN_LZB_EN
      msd = 3'd0;
      for (int unsigned k = 1; k < 8; k++)
         if (disp_nxt[{k[2:0], 2'b00} +: 4] != 4'h0) msd = k[2:0];
      if (state_nxt == SCAN && cnt_nxt >= GUARD && idx_nxt <= msd)
         en_nxt[idx_nxt] = 1'b1;
`else
      if (state_nxt == SCAN && cnt_nxt >= GUARD)
         en_nxt[idx_nxt] = 1'b1;
`endif
   end

endmodule
